// File: rtl/ddr_burst_rd_stream.sv
// Block-read master: splits one command into bursts of up to MAX_BURST beats and
// streams the returned beats out through a first-word-fall-through FIFO.
module ddr_burst_rd_stream #(
   parameter int MEM_DQ_WIDTH    = 16,
   parameter int LEN_WIDTH       = 16,
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int CMD_LEN_WIDTH   = 20,
   parameter int MAX_BURST       = 64,
   parameter int FIFO_DEPTH      = 128
) (
   input  logic                        system_clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [CTRL_ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [CMD_LEN_WIDTH-1:0]    cmd_len,
   output logic                        rd_burst_req,
   output logic [CTRL_ADDR_WIDTH-1:0]  rd_burst_addr,
   output logic [LEN_WIDTH-1:0]        rd_burst_len,
   input  logic [8*MEM_DQ_WIDTH-1:0]   rd_burst_data,
   input  logic                        rd_burst_data_valid,
   input  logic                        rd_burst_finish,
   output logic [8*MEM_DQ_WIDTH-1:0]   dout_data,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        proto_err
);
   // state   | meaning
   // S_IDLE  | waiting for a command, cmd_ready high
   // S_SPACE | waiting until the FIFO can hold the whole next burst
   // S_REQ   | rd_burst_req held until the first beat arrives
   // S_DATA  | collecting beats until rd_burst_finish
   typedef enum logic [1:0] {S_IDLE, S_SPACE, S_REQ, S_DATA} state_t;

   localparam int DW  = 8*MEM_DQ_WIDTH;
   localparam int FAW = $clog2(FIFO_DEPTH);

   state_t                       state_q, state_d;
   logic [CTRL_ADDR_WIDTH-1:0]   addr_q, addr_d, baddr_q, baddr_d;
   logic [CMD_LEN_WIDTH-1:0]     rem_q, rem_d;
   logic [LEN_WIDTH-1:0]         blen_q, blen_d, blen_c;
   logic [LEN_WIDTH:0]           beat_q, beat_d, beat_tot;
   logic                         done_q, done_d, err_q, err_d;

   logic [DW-1:0]                mem_q [FIFO_DEPTH];
   logic [FAW-1:0]               wr_ptr_q, rd_ptr_q;
   logic [FAW:0]                 cnt_q, space;
   logic                         in_burst, beat_ok, fifo_full, fifo_pop, fifo_push;

   assign fifo_full = (cnt_q == (FAW+1)'(FIFO_DEPTH));
   assign fifo_pop  = dout_valid & dout_ready;
   assign space     = (FAW+1)'(FIFO_DEPTH) - cnt_q;
   assign blen_c    = (rem_q > CMD_LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST)
                                                         : LEN_WIDTH'(rem_q);
   assign in_burst  = (state_q == S_REQ) || (state_q == S_DATA);
   // Beats past the announced burst length are dropped, but still counted for the length check.
   assign beat_ok   = in_burst && rd_burst_data_valid && (beat_q < {1'b0, blen_q});
   assign fifo_push = beat_ok && (!fifo_full || fifo_pop);
   assign beat_tot  = beat_q + {{LEN_WIDTH{1'b0}}, rd_burst_data_valid};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      baddr_d = baddr_q;
      blen_d  = blen_q;
      beat_d  = beat_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (!in_burst && (rd_burst_data_valid || rd_burst_finish)) err_d = 1'b1;
      if (beat_ok && fifo_full && !fifo_pop) err_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr;
               rem_d  = cmd_len;
               if (cmd_len == '0) done_d  = 1'b1;
               else               state_d = S_SPACE;
            end
         end
         S_SPACE: begin
            if (32'(space) >= 32'(blen_c)) begin
               baddr_d = addr_q;
               blen_d  = blen_c;
               beat_d  = '0;
               state_d = S_REQ;
            end
         end
         default: begin
            if (rd_burst_data_valid) begin
               beat_d = beat_tot;
               if (state_q == S_REQ) state_d = S_DATA;
            end
            if (rd_burst_finish) begin
               if (beat_tot != {1'b0, blen_q}) err_d = 1'b1;
               addr_d = addr_q + CTRL_ADDR_WIDTH'({blen_q, 3'b000});
               rem_d  = rem_q - CMD_LEN_WIDTH'(blen_q);
               beat_d = '0;
               if (rem_q == CMD_LEN_WIDTH'(blen_q)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_SPACE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         baddr_q  <= '0;
         blen_q   <= '0;
         beat_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         baddr_q <= baddr_d;
         blen_q  <= blen_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (fifo_push) wr_ptr_q <= wr_ptr_q + FAW'(1);
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
         if (fifo_push && !fifo_pop)      cnt_q <= cnt_q + (FAW+1)'(1);
         else if (!fifo_push && fifo_pop) cnt_q <= cnt_q - (FAW+1)'(1);
      end
   end

   always_ff @(posedge system_clk) begin
      if (fifo_push) mem_q[wr_ptr_q] <= rd_burst_data;
   end

   assign cmd_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign rd_burst_req  = (state_q == S_REQ);
   assign rd_burst_addr = baddr_q;
   assign rd_burst_len  = blen_q;
   assign dout_valid    = (cnt_q != '0);
   assign dout_data     = mem_q[rd_ptr_q];
   assign done          = done_q;
   assign proto_err     = err_q;
endmodule

// File: tb/tb_ddr_burst_rd_stream.sv
// Bench for ddr_burst_rd_stream: behavioural DDR read port, scoreboard on the output
// stream and one task per scenario.
module tb_ddr_burst_rd_stream;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [27:0]   cmd_addr;
   logic [19:0]   cmd_len;
   logic          rd_burst_req;
   logic [27:0]   rd_burst_addr;
   logic [15:0]   rd_burst_len;
   logic [127:0]  rd_burst_data;
   logic          rd_burst_data_valid, rd_burst_finish;
   logic [127:0]  dout_data;
   logic          dout_valid, dout_ready;
   logic          busy, done, proto_err;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int pop_cnt  = 0;
   int short_beats = 0;
   logic [127:0] sb [$];
   logic [27:0]  bq_addr [$];
   logic [15:0]  bq_len [$];

   bit          m_active = 1'b0, m_fin = 1'b0;
   int          m_rem, m_gap;
   logic [27:0] m_addr;

   always #5 clk = ~clk;

   ddr_burst_rd_stream dut (
      .system_clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
      .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
      .rd_burst_finish(rd_burst_finish),
      .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .busy(busy), .done(done), .proto_err(proto_err)
   );

   function automatic logic [127:0] data_of(input logic [27:0] a);
      logic [31:0] x;
      x = {4'h0, a};
      return {x ^ 32'hDEAD_BEEF, ~x, x + 32'h1357_9BDF, x ^ 32'h5A5A_5A5A};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: answers each request after a 2-cycle gap, finish one cycle after the last beat.
   initial begin
      rd_burst_data_valid = 1'b0;
      rd_burst_finish     = 1'b0;
      rd_burst_data       = '0;
      forever begin
         tick();
         rd_burst_data_valid = 1'b0;
         rd_burst_finish     = 1'b0;
         if (!rst_n) begin
            m_active = 1'b0;
            m_fin    = 1'b0;
         end else if (m_fin) begin
            rd_burst_finish = 1'b1;
            m_fin = 1'b0;
         end else if (m_active) begin
            if (m_gap > 0) m_gap--;
            else begin
               rd_burst_data_valid = 1'b1;
               rd_burst_data = data_of(m_addr);
               m_addr = m_addr + 28'd8;
               m_rem--;
               if (m_rem <= 0) begin
                  m_active = 1'b0;
                  m_fin = 1'b1;
               end
            end
         end else if (rd_burst_req) begin
            bq_addr.push_back(rd_burst_addr);
            bq_len.push_back(rd_burst_len);
            m_addr   = rd_burst_addr;
            m_rem    = int'(rd_burst_len) - short_beats;
            m_gap    = 2;
            m_active = 1'b1;
         end
      end
   end

   // Output monitor: pops the scoreboard on every accepted word, counts done pulses.
   initial begin
      logic [127:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (done) done_cnt++;
            if (dout_valid && dout_ready) begin
               pop_cnt++;
               n_checks++;
               if (sb.size() == 0) begin
                  n_errors++;
                  $display("FAIL pop_unexpected got=%h expected=none", dout_data);
               end else begin
                  exp = sb.pop_front();
                  if (dout_data !== exp) begin
                     n_errors++;
                     $display("FAIL dout_data got=%h expected=%h", dout_data, exp);
                  end
               end
            end
         end
      end
   end

   task automatic issue(input logic [27:0] a, input int len, input int nexp);
      for (int i = 0; i < nexp; i++) sb.push_back(data_of(a + 28'(i*8)));
      cmd_addr  = a;
      cmd_len   = 20'(len);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_for_done(input int d0, input int max, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (rnd) dout_ready = 1'($urandom_range(0, 1));
         tick();
         if (done_cnt > d0 && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; dout_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (cmd_ready !== 1'b1)     begin n_errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
      n_checks++; if (rd_burst_req !== 1'b0)  begin n_errors++; $display("FAIL rst_req got=%b exp=0", rd_burst_req); end
      n_checks++; if (rd_burst_addr !== '0 || rd_burst_len !== '0) begin n_errors++; $display("FAIL rst_burst got=%h/%h exp=0/0", rd_burst_addr, rd_burst_len); end
      n_checks++; if ({dout_valid, busy, done, proto_err} !== 4'b0) begin n_errors++; $display("FAIL rst_flags got=%b exp=0000", {dout_valid, busy, done, proto_err}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int d0; bit ok;
      bq_addr.delete(); bq_len.delete();
      d0 = done_cnt; dout_ready = 1'b1;
      issue(28'h100, 10, 10);
      n_checks++; if (rd_burst_req !== 1'b0) begin n_errors++; $display("FAIL lat_req_1 got=%b exp=0", rd_burst_req); end
      tick();
      n_checks++; if (rd_burst_req !== 1'b1) begin n_errors++; $display("FAIL lat_req_2 got=%b exp=1", rd_burst_req); end
      wait_for_done(d0, 200, 1'b0, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL single_timeout got=0 exp=1"); end
      repeat (3) tick();
      n_checks++; if (bq_addr.size() != 1 || bq_addr[0] !== 28'h100 || bq_len[0] !== 16'd10) begin n_errors++; $display("FAIL single_burst got=%0d bursts exp=1 (0x100,10)", bq_addr.size()); end
      n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0); end
      n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL single_err got=%b exp=0", proto_err); end
   endtask

   task automatic test_zero_len();
      int d0;
      bq_addr.delete(); bq_len.delete();
      d0 = done_cnt;
      issue(28'h40, 0, 0);
      n_checks++; if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL zero_pulse got=done%b rdy%b busy%b exp=1,1,0", done, cmd_ready, busy); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL zero_pulse_end got=%b exp=0", done); end
      repeat (10) tick();
      n_checks++; if (bq_addr.size() != 0 || done_cnt - d0 != 1) begin n_errors++; $display("FAIL zero_nobursts got=%0d bursts %0d done exp=0,1", bq_addr.size(), done_cnt - d0); end
   endtask

   task automatic test_multi();
      int d0; bit ok;
      logic [27:0] ea [3];
      logic [15:0] el [3];
      ea[0] = 28'h0; ea[1] = 28'h200; ea[2] = 28'h400;
      el[0] = 16'd64; el[1] = 16'd64; el[2] = 16'd22;
      bq_addr.delete(); bq_len.delete();
      d0 = done_cnt; dout_ready = 1'b1;
      issue(28'h0, 150, 150);
      wait_for_done(d0, 2000, 1'b0, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL multi_timeout got=0 exp=1"); end
      n_checks++; if (bq_addr.size() != 3) begin n_errors++; $display("FAIL multi_count got=%0d exp=3", bq_addr.size()); end
      for (int i = 0; i < 3 && i < bq_addr.size(); i++) begin
         n_checks++;
         if (bq_addr[i] !== ea[i] || bq_len[i] !== el[i]) begin
            n_errors++; $display("FAIL multi_burst%0d got=(%h,%0d) exp=(%h,%0d)", i, bq_addr[i], bq_len[i], ea[i], el[i]);
         end
      end
      n_checks++; if (done_cnt - d0 != 1 || proto_err !== 1'b0) begin n_errors++; $display("FAIL multi_done got=%0d err=%b exp=1,0", done_cnt - d0, proto_err); end
   endtask

   task automatic test_backpressure();
      int d0, p0; bit ok;
      bq_addr.delete(); bq_len.delete();
      d0 = done_cnt; p0 = pop_cnt; dout_ready = 1'b0;
      issue(28'h0, 200, 200);
      for (int i = 0; i < 600 && !(bq_addr.size() >= 2 && !m_active && !m_fin); i++) tick();
      repeat (20) tick();
      n_checks++; if (bq_addr.size() != 2 || rd_burst_req !== 1'b0 || busy !== 1'b1 || dout_valid !== 1'b1) begin n_errors++; $display("FAIL bp_full got=%0d bursts req%b busy%b exp=2,0,1", bq_addr.size(), rd_burst_req, busy); end
      dout_ready = 1'b1;
      repeat (63) tick();
      dout_ready = 1'b0;
      repeat (10) tick();
      n_checks++; if (bq_addr.size() != 2 || pop_cnt - p0 != 63) begin n_errors++; $display("FAIL bp_63 got=%0d bursts %0d pops exp=2,63", bq_addr.size(), pop_cnt - p0); end
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      for (int i = 0; i < 20 && bq_addr.size() < 3; i++) tick();
      n_checks++; if (bq_addr.size() != 3 || bq_addr[2] !== 28'h400 || bq_len[2] !== 16'd64) begin n_errors++; $display("FAIL bp_third got=%0d bursts exp=3 with (0x400,64)", bq_addr.size()); end
      dout_ready = 1'b1;
      wait_for_done(d0, 2000, 1'b0, ok);
      n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_timeout got=0 exp=1"); end
      n_checks++; if (bq_addr.size() != 4 || bq_addr[3] !== 28'h600 || bq_len[3] !== 16'd8) begin n_errors++; $display("FAIL bp_fourth got=%0d bursts exp=4 with (0x600,8)", bq_addr.size()); end
      n_checks++; if (pop_cnt - p0 != 200 || proto_err !== 1'b0) begin n_errors++; $display("FAIL bp_total got=%0d err=%b exp=200,0", pop_cnt - p0, proto_err); end
   endtask

   task automatic test_back_to_back();
      int d0, p0; bit ok;
      d0 = done_cnt; p0 = pop_cnt;
      issue(28'h1000, 70, 70);
      for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
         dout_ready = 1'($urandom_range(0, 1));
         tick();
      end
      n_checks++; if (cmd_ready !== 1'b1 || done_cnt - d0 != 1) begin n_errors++; $display("FAIL b2b_first got=rdy%b done%0d exp=1,1", cmd_ready, done_cnt - d0); end
      issue(28'h3000, 30, 30);
      wait_for_done(d0 + 1, 3000, 1'b1, ok);
      dout_ready = 1'b1;
      n_checks++; if (!ok || pop_cnt - p0 != 100) begin n_errors++; $display("FAIL b2b_total got=%0d words exp=100", pop_cnt - p0); end
   endtask

   task automatic test_short();
      int d0; bit ok;
      bq_addr.delete(); bq_len.delete();
      d0 = done_cnt; dout_ready = 1'b1; short_beats = 1;
      issue(28'h2000, 10, 9);
      wait_for_done(d0, 200, 1'b0, ok);
      short_beats = 0;
      n_checks++; if (!ok || proto_err !== 1'b1) begin n_errors++; $display("FAIL short_err got=%b exp=1", proto_err); end
      repeat (20) tick();
      n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL short_sticky got=%b exp=1", proto_err); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL short_clear got=%b exp=0", proto_err); end
   endtask

   task automatic test_reset_mid();
      int d0; bit ok;
      bq_addr.delete(); bq_len.delete();
      dout_ready = 1'b1;
      issue(28'h0, 150, 150);
      for (int i = 0; i < 600 && !(bq_addr.size() >= 2 && m_active); i++) tick();
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      n_checks++; if (rd_burst_req !== 1'b0 || dout_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL mid_reset got=req%b val%b rdy%b busy%b exp=0,0,1,0", rd_burst_req, dout_valid, cmd_ready, busy); end
      tick();
      sb.delete();
      rst_n = 1'b1;
      repeat (2) tick();
      bq_addr.delete(); bq_len.delete();
      d0 = done_cnt;
      issue(28'h800, 10, 10);
      wait_for_done(d0, 200, 1'b0, ok);
      n_checks++; if (!ok || bq_addr.size() != 1 || bq_addr[0] !== 28'h800 || proto_err !== 1'b0) begin n_errors++; $display("FAIL mid_newcmd got=%0d bursts err=%b exp=1 at 0x800,0", bq_addr.size(), proto_err); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_zero_len();
      test_multi();
      test_backpressure();
      test_back_to_back();
      test_short();
      test_reset_mid();
      repeat (5) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
